mem_access_stage: RTL and testbench

- MEM stage of the pipelined ARMv8 core. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Performs loads and stores through a req/ack data-memory port and captures load data for the MEM/WB register.
- Resolves the branch decision and target (CBZ/CBNZ/B/BR).
- Asserts mem_stall to freeze the pipeline while a memory access is outstanding.

---
 rtl/mem_access_stage_pkg.sv | 24 ++
 rtl/mem_access_stage_if.sv | 30 +++
 rtl/mem_branch_unit.sv | 29 ++
 rtl/mem_access_stage.sv | 169 ++++++++++++++++
 tb/tb_mem_access_stage.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_access_stage_pkg
// Shared definitions for the MEM stage: FSM state encoding, default bus
// widths, the bus reset constant and a small memory-op decode helper.
// ----------------------------------------------------------------------------
package mem_access_stage_pkg;

    localparam int DATA_WIDTH_DEF     = 64;
    localparam int REG_ADDR_WIDTH_DEF = 5;

    // Value loaded into every 64-bit bus register on reset.
    localparam logic [63:0] BUS_RST_VAL = 64'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_mem_op(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// ----------------------------------------------------------------------------
// mem_access_stage_if
// Data-memory req/ack port.
//   master (MEM stage): drives dmem_req, dmem_we, dmem_addr, dmem_wdata
//   slave  (memory)   : drives dmem_ack, dmem_rdata (rdata valid with ack)
// ----------------------------------------------------------------------------
interface mem_access_stage_if
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

    logic                  dmem_req;
    logic                  dmem_we;
    logic [DATA_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic                  dmem_ack;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/mem_branch_unit.sv
// ----------------------------------------------------------------------------
// mem_branch_unit
// Combinational branch resolution for CBZ/CBNZ/B/BR.
//   in : Branch, Uncondbranch, Branchreg, not_zero, zero_in,
//        pc_in (EX-computed target), read_data_1_in (register target)
//   out: PCSrc (taken), branch_target (next PC when taken)
// Kept standalone so an early-branch variant can reuse it.
// ----------------------------------------------------------------------------
module mem_branch_unit
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  Branch,
    input  logic                  Uncondbranch,
    input  logic                  Branchreg,
    input  logic                  not_zero,
    input  logic                  zero_in,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] read_data_1_in,
    output logic                  PCSrc,
    output logic [DATA_WIDTH-1:0] branch_target
);

    assign PCSrc = Uncondbranch | Branchreg | (Branch & zero_in) | (not_zero & ~zero_in);

    assign branch_target = Branchreg ? read_data_1_in : pc_in;

endmodule

// File: rtl/mem_access_stage.sv
// ----------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the pipelined ARMv8 core. Issues loads/stores on a req/ack
// data-memory port, registers load data for MEM/WB, resolves branches and
// stalls the upstream pipeline while an access is outstanding.
//
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   pc_in, read_data_1_in : branch targets (PC-relative / register)
//   alu_result_in         : memory address / ALU result
//   read_data_2_in        : store data
//   write_register_in     : destination register
//   zero_in, Branch, Uncondbranch, Branchreg, not_zero,
//   MemRead, MemWrite, MemtoReg : EX/MEM control
//   dmem (master)         : data-memory req/ack port
//   mem_stall             : freeze PC/IF/ID/EX and EX/MEM
//   PCSrc, branch_target  : branch decision and next PC
//   read_data_out         : registered load data
//   alu_result_out, write_register_out, MemtoReg_out : pass-through
//   mem_fault             : access aborted by timeout
//
// Build option: define MEM_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES REQ cycles without ack. Undefined, REQ waits forever and
// mem_fault is constant 0.
// ----------------------------------------------------------------------------
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     pc_in,
    input  logic [DATA_WIDTH-1:0]     alu_result_in,
    input  logic [DATA_WIDTH-1:0]     read_data_1_in,
    input  logic [DATA_WIDTH-1:0]     read_data_2_in,
    input  logic [REG_ADDR_WIDTH-1:0] write_register_in,
    input  logic                      zero_in,
    input  logic                      Branch,
    input  logic                      Uncondbranch,
    input  logic                      Branchreg,
    input  logic                      not_zero,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic                      MemtoReg,
    mem_access_stage_if.master        dmem,
    output logic                      mem_stall,
    output logic                      PCSrc,
    output logic [DATA_WIDTH-1:0]     branch_target,
    output logic [DATA_WIDTH-1:0]     read_data_out,
    output logic [DATA_WIDTH-1:0]     alu_result_out,
    output logic [REG_ADDR_WIDTH-1:0] write_register_out,
    output logic                      MemtoReg_out,
    output logic                      mem_fault
);

    localparam logic [DATA_WIDTH-1:0] RST_BUS = DATA_WIDTH'(BUS_RST_VAL);

    mem_state_e            state_q;
    logic                  req_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  mem_op;

`ifdef MEM_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter holds the number of ack-less REQ cycles already elapsed; the
    // cycle that sees TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th such cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            fault_q;
`endif

    assign mem_op = is_mem_op(MemRead, MemWrite);

    // DONE deliberately drops the stall so EX/MEM advances exactly once.
    assign mem_stall = (state_q == ST_REQ) || ((state_q == ST_IDLE) && mem_op);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= RST_BUS;
            wdata_q  <= RST_BUS;
            rdata_q  <= RST_BUS;
`ifdef MEM_TIMEOUT_EN
            to_cnt_q <= '0;
            fault_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_op) begin
                        req_q   <= 1'b1;
                        we_q    <= MemWrite;    // store wins when both are set
                        addr_q  <= alu_result_in;
                        wdata_q <= read_data_2_in;
                        state_q <= ST_REQ;
`ifdef MEM_TIMEOUT_EN
                        fault_q <= 1'b0;
`endif
                    end
                end
                ST_REQ: begin
                    // Ack takes priority over a same-cycle timeout.
                    if (dmem.dmem_ack) begin
                        req_q   <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= dmem.dmem_rdata;
                        end
                        state_q <= ST_DONE;
`ifdef MEM_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        req_q    <= 1'b0;
                        rdata_q  <= RST_BUS;
                        fault_q  <= 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= ST_DONE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign read_data_out   = rdata_q;

`ifdef MEM_TIMEOUT_EN
    assign mem_fault = fault_q;
`else
    assign mem_fault = 1'b0;
`endif

    assign alu_result_out     = alu_result_in;
    assign write_register_out = write_register_in;
    assign MemtoReg_out       = MemtoReg;

    mem_branch_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_branch (
        .Branch         (Branch),
        .Uncondbranch   (Uncondbranch),
        .Branchreg      (Branchreg),
        .not_zero       (not_zero),
        .zero_in        (zero_in),
        .pc_in          (pc_in),
        .read_data_1_in (read_data_1_in),
        .PCSrc          (PCSrc),
        .branch_target  (branch_target)
    );

endmodule

// File: tb/tb_mem_access_stage.sv
// ----------------------------------------------------------------------------
// tb_mem_access_stage
// Self-checking bench for mem_access_stage. Expected load results are pushed
// to a scoreboard queue when an access is driven and popped in DONE.
// Define MEM_TIMEOUT_EN for both bench and RTL to exercise the timeout path.
// ----------------------------------------------------------------------------
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int DW = 64;
    localparam int RW = 5;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] pc_in, alu_result_in, read_data_1_in, read_data_2_in;
    logic [RW-1:0] write_register_in;
    logic          zero_in, Branch, Uncondbranch, Branchreg, not_zero;
    logic          MemRead, MemWrite, MemtoReg;
    logic          mem_stall, PCSrc, MemtoReg_out, mem_fault;
    logic [DW-1:0] branch_target, read_data_out, alu_result_out;
    logic [RW-1:0] write_register_out;

    mem_access_stage_if #(.DATA_WIDTH(DW)) dmem ();

    always #5 clock = ~clock;

    mem_access_stage #(
        .DATA_WIDTH     (DW),
        .REG_ADDR_WIDTH (RW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .pc_in              (pc_in),
        .alu_result_in      (alu_result_in),
        .read_data_1_in     (read_data_1_in),
        .read_data_2_in     (read_data_2_in),
        .write_register_in  (write_register_in),
        .zero_in            (zero_in),
        .Branch             (Branch),
        .Uncondbranch       (Uncondbranch),
        .Branchreg          (Branchreg),
        .not_zero           (not_zero),
        .MemRead            (MemRead),
        .MemWrite           (MemWrite),
        .MemtoReg           (MemtoReg),
        .dmem               (dmem.master),
        .mem_stall          (mem_stall),
        .PCSrc              (PCSrc),
        .branch_target      (branch_target),
        .read_data_out      (read_data_out),
        .alu_result_out     (alu_result_out),
        .write_register_out (write_register_out),
        .MemtoReg_out       (MemtoReg_out),
        .mem_fault          (mem_fault)
    );

    int            n_tot = 0;
    int            n_bad = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model_rdo;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clr_ctl();
        zero_in = 1'b0; Branch = 1'b0; Uncondbranch = 1'b0; Branchreg = 1'b0;
        not_zero = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0;
    endtask

    // One complete memory instruction. waits = ack-less REQ cycles before ack;
    // with abort set, no ack is given and the stage must time out after
    // waits+1 REQ cycles.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [DW-1:0] rdat, input int waits, input bit abort);
        logic [DW-1:0] e;
        @(negedge clock);
        MemRead = rd; MemWrite = wr;
        alu_result_in = addr; read_data_2_in = wdata;
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = rdat;
        if (abort)   e = '0;
        else if (wr) e = model_rdo;
        else         e = rdat;
        exp_q.push_back(e);
        model_rdo = e;
        #1 chk({tag, ".stall_idle"}, 64'(mem_stall), 64'd1);
        @(posedge clock); @(negedge clock);
        chk({tag, ".fault_clr"}, 64'(mem_fault), 64'd0);
        for (int c = 0; c <= waits; c++) begin
            chk({tag, ".req"},   64'(dmem.dmem_req), 64'd1);
            chk({tag, ".we"},    64'(dmem.dmem_we),  64'(wr));
            chk({tag, ".addr"},  dmem.dmem_addr,     addr);
            chk({tag, ".wdata"}, dmem.dmem_wdata,    wdata);
            chk({tag, ".stall"}, 64'(mem_stall),     64'd1);
            if (c == waits && !abort) dmem.dmem_ack = 1'b1;
            @(posedge clock); @(negedge clock);
        end
        dmem.dmem_ack = 1'b0;
        chk({tag, ".done_stall"}, 64'(mem_stall),     64'd0);
        chk({tag, ".done_req"},   64'(dmem.dmem_req), 64'd0);
        chk({tag, ".fault"},      64'(mem_fault),     64'(abort));
        if (exp_q.size() == 0) chk({tag, ".sb_empty"}, 64'd1, 64'd0);
        else                   chk({tag, ".rdo"}, read_data_out, exp_q.pop_front());
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clock); @(negedge clock);
        chk({tag, ".idle_stall"}, 64'(mem_stall),     64'd0);
        chk({tag, ".idle_req"},   64'(dmem.dmem_req), 64'd0);
    endtask

    task automatic br(input string tag, input logic b, input logic u, input logic r,
                      input logic nz, input logic z, input logic [DW-1:0] pc,
                      input logic [DW-1:0] rd1, input logic e_src, input logic [DW-1:0] e_tgt);
        @(negedge clock);
        clr_ctl();
        Branch = b; Uncondbranch = u; Branchreg = r; not_zero = nz; zero_in = z;
        pc_in = pc; read_data_1_in = rd1;
        #1;
        chk({tag, ".pcsrc"},  64'(PCSrc), 64'(e_src));
        chk({tag, ".target"}, branch_target, e_tgt);
        chk({tag, ".stall"},  64'(mem_stall), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clr_ctl();
        pc_in = '0; alu_result_in = '0; read_data_1_in = '0; read_data_2_in = '0;
        write_register_in = '0;
        dmem.dmem_ack = 1'b0; dmem.dmem_rdata = '0;
        model_rdo = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;

        // reset state
        chk("rst.req",   64'(dmem.dmem_req), 64'd0);
        chk("rst.we",    64'(dmem.dmem_we),  64'd0);
        chk("rst.addr",  dmem.dmem_addr,     64'd0);
        chk("rst.wdata", dmem.dmem_wdata,    64'd0);
        chk("rst.rdo",   read_data_out,      64'd0);
        chk("rst.fault", 64'(mem_fault),     64'd0);
        chk("rst.stall", 64'(mem_stall),     64'd0);

        // pass-through
        alu_result_in = 64'hCAFE_0000_1234; write_register_in = 5'd7; MemtoReg = 1'b1;
        #1;
        chk("pt.alu",   alu_result_out,          64'hCAFE_0000_1234);
        chk("pt.wreg",  64'(write_register_out), 64'd7);
        chk("pt.m2r",   64'(MemtoReg_out),       64'd1);
        MemtoReg = 1'b0;

        access("ld0",  1'b1, 1'b0, 64'h100, 64'h0,  64'hDEADBEEF, 0, 1'b0);
        access("st4",  1'b0, 1'b1, 64'h180, 64'h55, 64'h9999,     4, 1'b0);
        access("ld2",  1'b1, 1'b0, 64'h208, 64'h0,  64'h0123_4567_89AB_CDEF, 2, 1'b0);
        access("both", 1'b1, 1'b1, 64'h300, 64'h77, 64'hBAD,      1, 1'b0);

        br("cbnz_t",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h40,   64'h0,   1'b1, 64'h40);
        br("cbnz_nt", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 64'h44,   64'h0,   1'b0, 64'h44);
        br("cbz_t",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h80,   64'h0,   1'b1, 64'h80);
        br("cbz_nt",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h84,   64'h0,   1'b0, 64'h84);
        br("b",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h1000, 64'h0,   1'b1, 64'h1000);
        br("br",      1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h40,   64'h200, 1'b1, 64'h200);
        @(negedge clock);
        clr_ctl();

`ifdef MEM_TIMEOUT_EN
        access("to_abort", 1'b1, 1'b0, 64'h400, 64'h0, 64'h1111, TO - 1, 1'b1);
        access("to_ack8",  1'b1, 1'b0, 64'h408, 64'h0, 64'h2222, TO - 1, 1'b0);
`endif

        // ack while idle is ignored
        @(negedge clock);
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 64'hABCD;
        @(posedge clock); @(negedge clock);
        dmem.dmem_ack = 1'b0;
        chk("idle_ack.rdo", read_data_out,      model_rdo);
        chk("idle_ack.req", 64'(dmem.dmem_req), 64'd0);

        // reset in the middle of REQ
        MemRead = 1'b1; alu_result_in = 64'h500;
        @(posedge clock); @(negedge clock);
        chk("rreq.req", 64'(dmem.dmem_req), 64'd1);
        reset = 1'b1; MemRead = 1'b0;
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        model_rdo = '0;
        chk("rreq.req_drop", 64'(dmem.dmem_req), 64'd0);
        chk("rreq.stall",    64'(mem_stall),     64'd0);
        chk("rreq.rdo",      read_data_out,      model_rdo);
        @(posedge clock); @(negedge clock);
        dmem.dmem_ack = 1'b1; dmem.dmem_rdata = 64'h1234;
        @(posedge clock); @(negedge clock);
        dmem.dmem_ack = 1'b0;
        chk("rreq.late_ack_rdo", read_data_out,      model_rdo);
        chk("rreq.late_ack_req", 64'(dmem.dmem_req), 64'd0);
        chk("sb.leftover",       64'(exp_q.size()),  64'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
